// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the upstream producer and the UART transmit serializer.
// The producer drives the master side and the serializer uses the slave side.
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, then stop bits.
// Advances one bit per baud tick and enables the tick generator while a frame is in flight.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_serializer_if.slave  tx,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 txd,
  output logic                 busy
);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_tx_serializer: illegal DATA_BITS/PARITY/STOP_BITS");
    end
  endgenerate

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [3:0]           bit_cnt, cnt_next;
  logic                 parity_bit, parity_next;
  logic                 txd_next;
  logic                 ready_q, ready_next;
  logic                 baud_en_next;
  logic                 busy_next;

  assign tx.tx_ready = ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      txd        <= 1'b1;
      ready_q    <= 1'b1;
      baud_en    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_cnt    <= cnt_next;
      parity_bit <= parity_next;
      txd        <= txd_next;
      ready_q    <= ready_next;
      baud_en    <= baud_en_next;
      busy       <= busy_next;
    end
  end

  // Every output is computed from the next state so all of them come straight off flops.
  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    cnt_next    = bit_cnt;
    parity_next = parity_bit;
    txd_next    = txd;

    case (state)
      S_IDLE: begin
        txd_next = 1'b1;
        if (tx.tx_valid && ready_q) begin
          state_next  = S_START;
          shift_next  = tx.tx_data;
          parity_next = (PARITY == 1) ? ~^tx.tx_data : ^tx.tx_data;
          cnt_next    = '0;
          txd_next    = 1'b0;
        end
      end

      S_START: begin
        if (baud_tick) begin
          state_next = S_DATA;
          txd_next   = shift_reg[0];
          shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
          cnt_next   = '0;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt == LAST_DATA) begin
            cnt_next = '0;
            if (PARITY != 0) begin
              state_next = S_PARITY;
              txd_next   = parity_bit;
            end else begin
              state_next = S_STOP;
              txd_next   = 1'b1;
            end
          end else begin
            txd_next   = shift_reg[0];
            shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
            cnt_next   = bit_cnt + 4'd1;
          end
        end
      end

      S_PARITY: begin
        if (baud_tick) begin
          state_next = S_STOP;
          txd_next   = 1'b1;
          cnt_next   = '0;
        end
      end

      S_STOP: begin
        txd_next = 1'b1;
        if (baud_tick) begin
          if (bit_cnt == LAST_STOP) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = bit_cnt + 4'd1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        txd_next   = 1'b1;
        cnt_next   = '0;
      end
    endcase

    ready_next   = (state_next == S_IDLE);
    baud_en_next = !ready_next;
    busy_next    = !ready_next;
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: three instances cover no parity, even parity
// with two stop bits, and odd parity; a monitor deserializes txd on every baud tick.
module tb_uart_tx_serializer;

  localparam int DIV  = 10;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NDUT-1:0] valid;
  logic [NDUT-1:0] ready;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] baud_en;
  logic [NDUT-1:0] baud_tick;
  logic [NDUT-1:0] txd;
  logic [NDUT-1:0] force_tick = '0;
  logic [7:0]      data [NDUT];

  uart_tx_serializer_if #(.DATA_BITS(8)) uif0 ();
  uart_tx_serializer_if #(.DATA_BITS(8)) uif1 ();
  uart_tx_serializer_if #(.DATA_BITS(8)) uif2 ();

  assign uif0.tx_valid = valid[0];
  assign uif0.tx_data  = data[0];
  assign ready[0]      = uif0.tx_ready;
  assign uif1.tx_valid = valid[1];
  assign uif1.tx_data  = data[1];
  assign ready[1]      = uif1.tx_ready;
  assign uif2.tx_valid = valid[2];
  assign uif2.tx_data  = data[2];
  assign ready[2]      = uif2.tx_ready;

  uart_tx_serializer dut0 (
    .clk(clk), .rst(rst), .tx(uif0.slave), .baud_tick(baud_tick[0]),
    .baud_en(baud_en[0]), .txd(txd[0]), .busy(busy[0])
  );

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx(uif1.slave), .baud_tick(baud_tick[1]),
    .baud_en(baud_en[1]), .txd(txd[1]), .busy(busy[1])
  );

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .tx(uif2.slave), .baud_tick(baud_tick[2]),
    .baud_en(baud_en[2]), .txd(txd[2]), .busy(busy[2])
  );

  typedef struct {
    int          dut;
    logic [15:0] frame;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  int          nbits    [NDUT];
  logic [15:0] cap      [NDUT];
  int          rise_cyc [NDUT];
  int          end_cyc  [NDUT];
  int          gap      [NDUT];
  int          hs_count [NDUT];
  int          tick_cnt [NDUT];
  logic [NDUT-1:0] prev_busy;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic int frameLen(input int d);
    case (d)
      0:       return 10;
      1:       return 12;
      default: return 11;
    endcase
  endfunction

  // Transmit order: bit 0 is the start bit; unused upper positions stay at the stop level.
  function automatic logic [15:0] buildFrame(input int d, input logic [7:0] v, input logic pbit);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = v[k];
    if (d != 0) f[9] = pbit;
    return f;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Tick generator model: phase restarts while baud_en is low, plus forced stray pulses.
  initial begin
    baud_tick = '0;
    for (int i = 0; i < NDUT; i++) tick_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #3;
      for (int i = 0; i < NDUT; i++) begin
        if (force_tick[i]) begin
          baud_tick[i]  = 1'b1;
          force_tick[i] = 1'b0;
        end else if (!baud_en[i]) begin
          tick_cnt[i]  = 0;
          baud_tick[i] = 1'b0;
        end else if (tick_cnt[i] == DIV - 1) begin
          tick_cnt[i]  = 0;
          baud_tick[i] = 1'b1;
        end else begin
          tick_cnt[i]++;
          baud_tick[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: a tick seen while busy closes the bit currently on txd.
  initial begin
    exp_t e;
    prev_busy = '0;
    for (int i = 0; i < NDUT; i++) begin
      nbits[i] = 0; cap[i] = '1; rise_cyc[i] = 0; end_cyc[i] = 0;
      gap[i] = 0; hs_count[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (rst) begin
          nbits[i]     = 0;
          prev_busy[i] = 1'b0;
        end else begin
          if (valid[i] && ready[i]) hs_count[i]++;
          if (busy[i] && !prev_busy[i]) begin
            checkOutput($sformatf("start_lines_dut%0d", i),
                        {13'b0, txd[i], baud_en[i], ready[i]}, 16'h0002);
            rise_cyc[i] = cyc;
            gap[i]      = cyc - end_cyc[i];
            nbits[i]    = 0;
            cap[i]      = '1;
          end
          if (busy[i] && baud_tick[i]) begin
            if (nbits[i] == 0)
              checkOutput($sformatf("start_width_dut%0d", i),
                          16'(cyc - rise_cyc[i]), 16'(DIV - 1));
            cap[i][nbits[i]] = txd[i];
            nbits[i]++;
            if (nbits[i] == frameLen(i)) begin
              end_cyc[i] = cyc;
              nbits[i]   = 0;
              if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_frame dut%0d: got=0x%0h expected=none", i, cap[i]);
              end else begin
                e = sb_q.pop_front();
                checkOutput("frame_dut_id", 16'(i), 16'(e.dut));
                checkOutput($sformatf("frame_bits_dut%0d", i), cap[i], e.frame);
              end
            end
          end
          prev_busy[i] = busy[i];
        end
      end
    end
  end

  task automatic waitAccept(input int d);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (valid[d] && ready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput($sformatf("accept_timeout_dut%0d", d), 16'(ok), 16'h1);
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle(input int d);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (!busy[d] && ready[d] && sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("frame_done_dut%0d", d), 16'(ok), 16'h1);
  endtask

  task automatic applyStimulus(input int d, input logic [7:0] v, input logic pbit,
                               input logic stray);
    exp_t e;
    e.dut   = d;
    e.frame = buildFrame(d, v, pbit);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
    data[d]  = v;
    valid[d] = 1'b1;
    if (stray) force_tick[d] = 1'b1;
    waitAccept(d);
    valid[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    rst   = 1'b1;
    valid = '0;
    for (int i = 0; i < NDUT; i++) data[i] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    $display("[TB] reset then idle");
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++)
        checkOutput($sformatf("idle_lines_dut%0d", i),
                    {12'b0, txd[i], ready[i], baud_en[i], busy[i]}, 16'h000C);
    end

    $display("[TB] single byte 0x55, no parity");
    applyStimulus(0, 8'h55, 1'b0, 1'b0);
    waitIdle(0);

    $display("[TB] even parity, two stop bits");
    applyStimulus(1, 8'h07, 1'b1, 1'b0);
    waitIdle(1);
    applyStimulus(1, 8'h80, 1'b1, 1'b0);
    waitIdle(1);
    applyStimulus(1, 8'h00, 1'b0, 1'b0);
    waitIdle(1);

    $display("[TB] odd parity");
    applyStimulus(2, 8'h07, 1'b0, 1'b0);
    waitIdle(2);
    applyStimulus(2, 8'h55, 1'b1, 1'b0);
    waitIdle(2);
    applyStimulus(2, 8'hFE, 1'b0, 1'b0);
    waitIdle(2);

    $display("[TB] back-to-back with valid held high");
    e.dut = 0; e.frame = buildFrame(0, 8'hA5, 1'b0); sb_q.push_back(e);
    e.dut = 0; e.frame = buildFrame(0, 8'h3C, 1'b0); sb_q.push_back(e);
    @(posedge clk);
    #2;
    hs_count[0] = 0;
    data[0]  = 8'hA5;
    valid[0] = 1'b1;
    waitAccept(0);
    data[0] = 8'h3C;
    waitAccept(0);
    valid[0] = 1'b0;
    data[0]  = 8'hFF;
    waitIdle(0);
    checkOutput("b2b_handshakes", 16'(hs_count[0]), 16'd2);
    checkOutput("b2b_gap_clks", 16'(gap[0]), 16'd2);

    $display("[TB] reset during data bit 3");
    e.dut = 0; e.frame = buildFrame(0, 8'hFF, 1'b0); sb_q.push_back(e);
    @(posedge clk);
    #2;
    data[0]  = 8'hFF;
    valid[0] = 1'b1;
    waitAccept(0);
    valid[0] = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (nbits[0] == 4) break;
    end
    @(posedge clk);
    #3;
    checkOutput("pre_reset_baud_en", 16'(baud_en[0]), 16'h1);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_lines", {12'b0, txd[0], ready[0], baud_en[0], busy[0]}, 16'h000C);
    void'(sb_q.pop_back());
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(0, 8'h12, 1'b0, 1'b0);
    waitIdle(0);

    $display("[TB] stray ticks");
    @(posedge clk);
    #2;
    force_tick[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("stray_idle_lines", {12'b0, txd[0], ready[0], baud_en[0], busy[0]}, 16'h000C);
    applyStimulus(0, 8'hC3, 1'b0, 1'b1);
    waitIdle(0);
    applyStimulus(1, 8'h3A, 1'b0, 1'b1);
    waitIdle(1);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit serializer sitting directly downstream of the baud tick generator. It accepts a parallel byte over a valid/ready handshake and drives the generator's enable input while a frame is in flight. It shifts the byte out LSB-first as start, data, optional parity and stop bits, advancing one bit per baud tick. Its output drives the FPGA TX pin toward the Raspberry Pi.

Parameters:
DATA_BITS, 8, number of data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even; other values are illegal.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-high reset.
tx_data  in  DATA_BITS  byte to send; sampled only on acceptance.
tx_valid  in  1  upstream has a byte to send.
tx_ready  out  1  block can accept a byte; high only in IDLE.
baud_tick  in  1  one-clk pulse at the baud rate (oversampling 1) from the tick generator.
baud_en  out  1  enable to the tick generator; high in every state except IDLE.
txd  out  1  serial line; idle level is high.
busy  out  1  frame in progress; equals the inverse of tx_ready.

Behaviour:
- Reset values: state = IDLE, txd = 1, tx_ready = 1, busy = 0, baud_en = 0, shift register = 0, bit counter = 0.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: on tx_valid & tx_ready. In the same edge, latch tx_data into the shift register and compute the parity bit from it.
- Next-cycle outputs after acceptance: txd = 0, baud_en = 1, tx_ready = 0, busy = 1.
- START -> DATA: on baud_tick. txd takes data bit 0 and the bit counter is cleared.
- DATA: on each baud_tick, shift right and present the next bit on txd.
  - After bit DATA_BITS-1 has been held for one tick, go to PARITY when PARITY != 0, otherwise go to STOP.
  - On entering STOP, txd = 1.
- PARITY: txd = parity bit.
  - Odd parity: total count of ones in data plus parity bit is odd.
  - Even parity: total count is even.
  - On baud_tick, go to STOP with txd = 1.
- STOP: hold txd = 1 for STOP_BITS ticks using the counter. On the final tick, go to IDLE; baud_en drops and tx_ready rises on the next cycle.
- Bit timing: every bit is held from one baud_tick (or acceptance, for the start bit) to the next baud_tick.
- The tick generator restarts its phase whenever baud_en is low, so the start bit lasts roughly one bit period.
- baud_tick while in IDLE is ignored.
- baud_tick in the acceptance cycle is ignored, because the state is still IDLE.
- tx_valid is ignored while busy. tx_data changes during a frame have no effect.
- Back-to-back frames: the minimum gap is 1 clk of IDLE after the last stop bit, so the stop level lasts STOP_BITS bit periods plus 1–2 clks.
- tx_valid may stay high continuously; the next byte is accepted in that IDLE cycle.
- Reset mid-frame: txd returns to 1 immediately (asynchronous) and baud_en goes to 0. The frame is lost and no partial completion occurs.
- Illegal parameter values are flagged by a simulation-time check that stops elaboration. There is no synthesis fallback.

Test Plan:
- Reset then idle: hold rst for 3 clks, release, and drive no valid for 100 clks -> txd = 1, tx_ready = 1, baud_en = 0 throughout.
- Single byte 0x55, default parameters, ticks every 10 clks -> txd sequence per tick is 0,1,0,1,0,1,0,1,0,1. Total 10 bit periods, then tx_ready re-asserts. The sink deserializes 0x55.
- PARITY = 2, byte 0x07 -> parity bit = 1. PARITY = 1, same byte -> parity bit = 0. STOP_BITS = 2 -> line high for 2 tick periods before IDLE.
- Back-to-back: tx_valid held high with 0xA5 then 0x3C -> both frames are correct. The gap between frames is at most 2 clks beyond the stop bit, and exactly 2 handshakes occur.
- Reset asserted during data bit 3 of 0xFF -> txd = 1 within the same cycle and baud_en = 0. A new byte 0x12 after release is sent intact.
- Stray ticks: pulse baud_tick in IDLE and in the acceptance cycle -> no state change, and the start bit still lasts exactly one full tick interval.
